// File: rtl/char_in_feeder.sv
// Byte FIFO that feeds io_inpr / io_fgiset one character per FGI handshake.
// Define CHAR_IN_FEEDER_TRISTATE_EN to float io_inpr outside SET, WAIT_SET and WAIT_CLR.
module char_in_feeder #(
   parameter int DEPTH       = 16,
   parameter int GAP_CYCLES  = 4,
   parameter int SET_TIMEOUT = 64
) (
   input  logic                     io_clock,
   input  logic                     io_reset_n,
   input  logic                     io_wr_en,
   input  logic [7:0]               io_wr_data,
   input  logic                     io_fgi,
   output logic [7:0]               io_inpr,
   output logic                     io_fgiset,
   output logic                     io_full,
   output logic                     io_empty,
   output logic [$clog2(DEPTH):0]   io_count,
   output logic                     io_overflow,
   output logic                     io_busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(SET_TIMEOUT + 1);
   localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SET,
      WAIT_SET,
      WAIT_CLR,
      GAP
   } state_t;

   logic [7:0]    mem [DEPTH];

   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    inpr_q, inpr_d;
   logic          fgiset_q, fgiset_d;
   logic          busy_q, busy_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [GW-1:0] gap_q, gap_d;

   logic          push;
   logic          pop;

   // The only pop is the LOAD cycle, which is entered solely from a non-empty FIFO.
   assign push = io_wr_en & ~full_q;
   assign pop  = (state_q == LOAD);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (io_wr_en & full_q);
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
   end

   always_comb begin
      state_d = state_q;
      inpr_d  = inpr_q;
      tmo_d   = tmo_q;
      gap_d   = gap_q;
      unique case (state_q)
         IDLE: begin
            if (!empty_q && !io_fgi) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            inpr_d  = mem[rd_ptr_q];
            state_d = SET;
         end
         SET: begin
            tmo_d   = '0;
            state_d = WAIT_SET;
         end
         WAIT_SET: begin
            if (io_fgi) begin
               state_d = WAIT_CLR;
            end else begin
               tmo_d = tmo_q + 1'b1;
               if (tmo_d == TW'(SET_TIMEOUT)) begin
                  state_d = SET;
               end
            end
         end
         WAIT_CLR: begin
            if (!io_fgi) begin
               gap_d   = GW'(GAP_CYCLES);
               state_d = GAP;
            end
         end
         GAP: begin
            // A loaded count of 0 or 1 both give a single GAP cycle.
            if (gap_q <= GW'(1)) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      fgiset_d = (state_d == SET);
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge io_clock) begin
      if (push) begin
         mem[wr_ptr_q] <= io_wr_data;
      end
   end

   always_ff @(posedge io_clock or negedge io_reset_n) begin
      if (!io_reset_n) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         inpr_q     <= 8'h00;
         fgiset_q   <= 1'b0;
         busy_q     <= 1'b0;
         tmo_q      <= '0;
         gap_q      <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
         inpr_q     <= inpr_d;
         fgiset_q   <= fgiset_d;
         busy_q     <= busy_d;
         tmo_q      <= tmo_d;
         gap_q      <= gap_d;
      end
   end

`ifdef CHAR_IN_FEEDER_TRISTATE_EN
   assign io_inpr = ((state_q == SET) || (state_q == WAIT_SET) || (state_q == WAIT_CLR))
                    ? inpr_q : 8'hzz;
`else
   assign io_inpr = inpr_q;
`endif

   assign io_fgiset   = fgiset_q;
   assign io_full     = full_q;
   assign io_empty    = empty_q;
   assign io_count    = count_q;
   assign io_overflow = overflow_q;
   assign io_busy     = busy_q;

endmodule
